// File: rtl/dl11_bus_responder.sv
// dl11_bus_responder
//   DL11-style serial line unit sitting as a responder on the VM1 CPU bus.
//   Four word registers at BASE_ADDR (RCSR, RBUF, XCSR, XBUF), one 8N1 UART
//   (transmit + receive) and two vectored interrupt requests (RX, TX).
// Ports
//   clk_sys, reset_n        system clock / async active-low reset
//   ce                      bus clock enable qualifying the handshake
//   bus_reset               CPU INIT, synchronous, active high
//   bus_addr/sync/stb/we    CPU address, address-valid, data strobe, write
//   bus_wtbt                byte lanes: [0] low byte, [1] high byte
//   bus_din / bus_dout      write data in / read data out (0 when unselected)
//   bus_ack                 RPLY back to the CPU
//   virq_req_*/virq_ack_*   interrupt requests and vic acknowledges
//   rxd / txd               serial line in (async) / out (idle high)
module dl11_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'o177560,
    parameter logic [15:0] BAUD_DIV  = 16'd434
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        bus_reset,
    input  logic [15:0] bus_addr,
    input  logic        bus_sync,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    output logic        virq_req_rx,
    input  logic        virq_ack_rx,
    output logic        virq_req_tx,
    input  logic        virq_ack_tx,
    input  logic        rxd,
    output logic        txd
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} line_state_t;

    localparam logic [15:0] BIT_RELOAD  = BAUD_DIV - 16'd1;
    localparam logic [15:0] HALF_RELOAD = (BAUD_DIV >> 1) - 16'd1;

    // ---------------- register state ----------------
    logic       rie, tie, maint;
    logic       done, ovr, ferr;
    logic [7:0] rbuf_data;
    logic [7:0] hold;
    logic       hold_full;
    logic       ready;

    // READY simply means the holding register can take another byte.
    assign ready = ~hold_full;

    // ---------------- bus decode ----------------
    logic        sel;
    logic [1:0]  reg_idx;
    logic        access, wr, rd;
    logic        rbuf_rd_clr, xbuf_wr;
    logic [15:0] rd_data;

    assign sel         = bus_sync & (bus_addr[15:3] == BASE_ADDR[15:3]);
    assign reg_idx     = bus_addr[2:1];
    // Side effects fire only on the cycle ack is raised, so a held strobe
    // produces exactly one write or one RBUF clear.
    assign access      = ce & sel & bus_stb & ~bus_ack;
    assign wr          = access & bus_we;
    assign rd          = access & ~bus_we;
    assign rbuf_rd_clr = rd & (reg_idx == 2'd1);
    assign xbuf_wr     = wr & (reg_idx == 2'd3) & bus_wtbt[0] & ready;

    always_comb begin
        rd_data = 16'd0;
        case (reg_idx)
            2'd0:    rd_data = {8'd0, done, rie, 6'd0};
            2'd1:    rd_data = {ovr, ferr, 6'd0, rbuf_data};
            2'd2:    rd_data = {8'd0, ready, tie, 3'd0, maint, 2'd0};
            default: rd_data = 16'd0;
        endcase
    end

    assign bus_dout = (sel & bus_stb & ~bus_we) ? rd_data : 16'd0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            bus_ack <= 1'b0;
        else if (ce) begin
            if (sel & bus_stb & ~bus_ack)
                bus_ack <= 1'b1;
            else if (~bus_stb)
                bus_ack <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    line_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_sh;
    logic        tx_tick, tx_load, tx_line;

    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            S_IDLE:  if (hold_full) begin tx_load = 1'b1; tx_next = S_START; end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) begin
                         // A waiting byte goes straight into its start bit.
                         if (hold_full) begin tx_load = 1'b1; tx_next = S_START; end
                         else tx_next = S_IDLE;
                     end
            default: tx_next = S_IDLE;
        endcase
        if (bus_reset) begin
            tx_next = S_IDLE;
            tx_load = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_idx   <= 3'd0;
            tx_sh    <= 8'd0;
        end else begin
            tx_state <= tx_next;
            if (bus_reset) begin
                tx_cnt <= 16'd0;
                tx_idx <= 3'd0;
            end else if (tx_load) begin
                tx_cnt <= BIT_RELOAD;
                tx_idx <= 3'd0;
                tx_sh  <= hold;
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= BIT_RELOAD;
                    if (tx_state == S_DATA) begin
                        tx_sh  <= tx_sh >> 1;
                        tx_idx <= tx_idx + 3'd1;   // wraps 7->0 on entry to STOP
                    end
                end else
                    tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_sh[0];
            default: tx_line = 1'b1;
        endcase
    end

    // Loopback keeps the external line quiet.
    assign txd = maint ? 1'b1 : tx_line;

    // ---------------- receiver ----------------
    line_state_t rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_src, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_sh;
    logic        rx_tick, rx_fall, rx_complete;

    assign rx_src  = maint ? tx_line : rx_s2;
    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_fall = rx_prev & ~rx_src;

    always_comb begin
        rx_next     = rx_state;
        rx_complete = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            // A start bit that is high again at mid-bit was a glitch.
            S_START: if (rx_tick) rx_next = rx_src ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) begin rx_complete = 1'b1; rx_next = S_IDLE; end
            default: rx_next = S_IDLE;
        endcase
        if (bus_reset) begin
            rx_next     = S_IDLE;
            rx_complete = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_idx   <= 3'd0;
            rx_sh    <= 8'd0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_src;
            rx_state <= rx_next;
            if (bus_reset) begin
                rx_cnt <= 16'd0;
                rx_idx <= 3'd0;
            end else if (rx_state == S_IDLE) begin
                if (rx_fall) begin
                    rx_cnt <= HALF_RELOAD;   // first sample lands mid start bit
                    rx_idx <= 3'd0;
                end
            end else if (rx_tick) begin
                rx_cnt <= BIT_RELOAD;
                if (rx_state == S_DATA) begin
                    rx_sh  <= {rx_src, rx_sh[7:1]};
                    rx_idx <= rx_idx + 3'd1;
                end
            end else
                rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // ---------------- CSR / buffer registers ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rie       <= 1'b0;
            tie       <= 1'b0;
            maint     <= 1'b0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
            rbuf_data <= 8'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
        end else if (bus_reset) begin
            rie       <= 1'b0;
            tie       <= 1'b0;
            maint     <= 1'b0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
        end else begin
            if (wr & bus_wtbt[0]) begin
                if (reg_idx == 2'd0)
                    rie <= bus_din[6];
                if (reg_idx == 2'd2) begin
                    tie   <= bus_din[6];
                    maint <= bus_din[2];
                end
            end
            if (xbuf_wr) begin
                hold      <= bus_din[7:0];
                hold_full <= 1'b1;
            end
            if (tx_load)
                hold_full <= 1'b0;
            if (rbuf_rd_clr) begin
                done <= 1'b0;
                ovr  <= 1'b0;
                ferr <= 1'b0;
            end
            // Placed last so a byte landing on the same cycle as an RBUF
            // read wins; the read already consumed the old byte, so no overrun.
            if (rx_complete) begin
                rbuf_data <= rx_sh;
                ferr      <= ~rx_src;
                ovr       <= done & ~rbuf_rd_clr;
                done      <= 1'b1;
            end
        end
    end

    // ---------------- interrupt requests ----------------
    logic rx_cond, rx_cond_q, tx_cond, tx_cond_q;

    assign rx_cond = done & rie;
    assign tx_cond = ready & tie;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rx_cond_q   <= 1'b0;
            tx_cond_q   <= 1'b0;
            virq_req_rx <= 1'b0;
            virq_req_tx <= 1'b0;
        end else begin
            rx_cond_q <= rx_cond;
            tx_cond_q <= tx_cond;
            if (bus_reset) begin
                virq_req_rx <= 1'b0;
                virq_req_tx <= 1'b0;
            end else begin
                // Rising edge of the condition takes priority over an ack.
                if (rx_cond & ~rx_cond_q)          virq_req_rx <= 1'b1;
                else if (virq_ack_rx | ~rx_cond)   virq_req_rx <= 1'b0;
                if (tx_cond & ~tx_cond_q)          virq_req_tx <= 1'b1;
                else if (virq_ack_tx | ~tx_cond)   virq_req_tx <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus_din[15:8], bus_din[5:3], bus_din[1:0], bus_wtbt[1], bus_addr[0]};

endmodule

// File: tb/tb_dl11_bus_responder.sv
module tb_dl11_bus_responder;

    localparam int BD = 16;
    localparam logic [15:0] RCSR = 16'o177560;
    localparam logic [15:0] RBUF = 16'o177562;
    localparam logic [15:0] XCSR = 16'o177564;
    localparam logic [15:0] XBUF = 16'o177566;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        bus_reset = 1'b0;
    logic [15:0] bus_addr = 16'd0;
    logic        bus_sync = 1'b0;
    logic        bus_stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_wtbt = 2'b00;
    logic [15:0] bus_din = 16'd0;
    logic [15:0] bus_dout;
    logic        bus_ack;
    logic        virq_req_rx;
    logic        virq_ack_rx = 1'b0;
    logic        virq_req_tx;
    logic        virq_ack_tx = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [15:0] exp_rd[$];
    logic [15:0] rd_addr[$];
    logic [7:0]  exp_tx[$];
    int          start_cyc[$];
    logic        tx_mon_en = 1'b0;
    logic        mon_busy = 1'b0;

    dl11_bus_responder #(.BASE_ADDR(16'o177560), .BAUD_DIV(16'(BD))) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .bus_reset(bus_reset),
        .bus_addr(bus_addr), .bus_sync(bus_sync), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_wtbt(bus_wtbt), .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack),
        .virq_req_rx(virq_req_rx), .virq_ack_rx(virq_ack_rx),
        .virq_req_tx(virq_req_tx), .virq_ack_tx(virq_ack_tx),
        .rxd(rxd), .txd(txd)
    );

    always #5 clk_sys = ~clk_sys;

    initial forever begin @(posedge clk_sys); cyc++; end
    initial forever begin @(negedge clk_sys); ce = ~ce; end

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic we, input logic [1:0] bt,
                             input logic [15:0] d);
        int n;
        @(negedge clk_sys);
        bus_addr = a; bus_we = we; bus_wtbt = bt; bus_din = d;
        bus_sync = 1'b1; bus_stb = 1'b1;
        n = 0;
        while (!bus_ack && n < 40) begin @(negedge clk_sys); n++; end
        if (!bus_ack) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout_%o: got 0 expected 1", a);
        end
        bus_stb = 1'b0; bus_sync = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00;
        n = 0;
        while (bus_ack && n < 40) begin @(negedge clk_sys); n++; end
        if (bus_ack) begin
            n_chk++; n_fail++;
            $display("FAIL ack_release_%o: got 1 expected 0", a);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] e);
        exp_rd.push_back(e);
        rd_addr.push_back(a);
        bus_cycle(a, 1'b0, 2'b00, 16'd0);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [1:0] bt, input logic [15:0] d);
        bus_cycle(a, 1'b1, bt, d);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk_sys);
        rxd = 1'b0;
        repeat (BD) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BD) @(negedge clk_sys);
        end
        rxd = stop;
        repeat (BD) @(negedge clk_sys);
        rxd = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    // Bus monitor: read data is what was presented on the edge that raised ack.
    initial begin
        logic        ack_q;
        logic [15:0] dout_q, e, a;
        ack_q = 1'b0;
        dout_q = 16'd0;
        forever begin
            @(negedge clk_sys); #1;
            dout_q = bus_dout;
            @(posedge clk_sys); #1;
            if (bus_ack && !ack_q && bus_stb && !bus_we) begin
                if (exp_rd.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_read: got %o expected none", dout_q);
                end else begin
                    e = exp_rd.pop_front();
                    a = rd_addr.pop_front();
                    chk16($sformatf("read_%o", a), dout_q, e);
                end
            end
            ack_q = bus_ack;
        end
    end

    // Serial monitor: decodes 8N1 frames on txd at mid-bit.
    initial begin
        logic [7:0] b, e;
        b = 8'd0;
        forever begin
            @(posedge clk_sys); #1;
            if (tx_mon_en && txd === 1'b0) begin
                mon_busy = 1'b1;
                start_cyc.push_back(cyc);
                repeat (BD/2) @(posedge clk_sys);
                #1;
                chk1("tx_start_bit", txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(posedge clk_sys);
                    #1;
                    b[i] = txd;
                end
                repeat (BD) @(posedge clk_sys);
                #1;
                chk1("tx_stop_bit", txd, 1'b1);
                if (exp_tx.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_tx_frame: got %h expected none", b);
                end else begin
                    e = exp_tx.pop_front();
                    chk16("tx_byte", {8'h00, b}, {8'h00, e});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk_sys);
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic seen_low;
        int   n;

        // 1. reset state and decode
        repeat (3) @(negedge clk_sys);
        chk1("reset_txd", txd, 1'b1);
        chk1("reset_ack", bus_ack, 1'b0);
        chk1("reset_req_rx", virq_req_rx, 1'b0);
        chk1("reset_req_tx", virq_req_tx, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        bus_read(RCSR, 16'o000000);
        bus_read(XCSR, 16'o000200);
        bus_read(RBUF, 16'o000000);
        bus_read(XBUF, 16'o000000);
        @(negedge clk_sys);
        bus_addr = 16'o177570; bus_sync = 1'b1; bus_stb = 1'b1; bus_we = 1'b0;
        seen_low = 1'b0;
        repeat (6) begin
            @(negedge clk_sys);
            if (bus_ack !== 1'b0 || bus_dout !== 16'd0) seen_low = 1'b1;
        end
        chk1("unsel_no_ack_zero_dout", seen_low, 1'b0);
        bus_sync = 1'b0; bus_stb = 1'b0;

        // 2. transmit, back-to-back, discarded write while busy
        start_cyc.delete();
        tx_mon_en = 1'b1;
        exp_tx.push_back(8'h55);
        bus_write(XBUF, 2'b01, 16'h0055);
        bus_read(XCSR, 16'o000200);
        exp_tx.push_back(8'hC3);
        bus_write(XBUF, 2'b01, 16'h00C3);
        bus_read(XCSR, 16'o000000);
        bus_write(XBUF, 2'b01, 16'h00FF);
        n = 0;
        while ((exp_tx.size() != 0 || mon_busy) && n < 800) begin @(negedge clk_sys); n++; end
        chk1("tx_drain_timeout", (exp_tx.size() != 0 || mon_busy), 1'b0);
        repeat (12 * BD) @(negedge clk_sys);
        chk16("tx_frame_count", 16'(start_cyc.size()), 16'd2);
        if (start_cyc.size() >= 2)
            chk16("tx_b2b_gap", 16'(start_cyc[1] - start_cyc[0]), 16'(10 * BD));
        bus_read(XCSR, 16'o000200);

        // 3. receive one byte
        send_rx(8'hA5, 1'b1);
        bus_read(RCSR, 16'o000200);
        bus_read(RBUF, 16'h00A5);
        bus_read(RCSR, 16'o000000);

        // 4. overrun, framing error, glitch
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(RBUF, 16'h8022);
        bus_read(RCSR, 16'o000000);
        send_rx(8'h33, 1'b0);
        bus_read(RBUF, 16'h4033);
        @(negedge clk_sys);
        rxd = 1'b0;
        repeat (5) @(negedge clk_sys);
        rxd = 1'b1;
        repeat (40) @(negedge clk_sys);
        bus_read(RCSR, 16'o000000);

        // 5. interrupts and byte lanes
        bus_write(RCSR, 2'b10, 16'o000100);
        bus_read(RCSR, 16'o000000);
        bus_write(RCSR, 2'b01, 16'o000100);
        bus_read(RCSR, 16'o000100);
        chk1("rx_irq_idle", virq_req_rx, 1'b0);
        send_rx(8'h5A, 1'b1);
        chk1("rx_irq_set", virq_req_rx, 1'b1);
        virq_ack_rx = 1'b1;
        @(negedge clk_sys);
        virq_ack_rx = 1'b0;
        chk1("rx_irq_ack", virq_req_rx, 1'b0);
        repeat (5) @(negedge clk_sys);
        chk1("rx_irq_stays_clear", virq_req_rx, 1'b0);
        bus_read(RCSR, 16'o000300);
        bus_read(RBUF, 16'h005A);
        bus_write(RCSR, 2'b01, 16'o000000);
        chk1("tx_irq_idle", virq_req_tx, 1'b0);
        bus_write(XCSR, 2'b01, 16'o000100);
        chk1("tx_irq_set", virq_req_tx, 1'b1);
        repeat (10) @(negedge clk_sys);
        chk1("tx_irq_held", virq_req_tx, 1'b1);
        virq_ack_tx = 1'b1;
        @(negedge clk_sys);
        virq_ack_tx = 1'b0;
        chk1("tx_irq_ack", virq_req_tx, 1'b0);
        repeat (10) @(negedge clk_sys);
        chk1("tx_irq_stays_clear", virq_req_tx, 1'b0);
        bus_read(XCSR, 16'o000300);
        bus_write(XCSR, 2'b01, 16'o000000);

        // 6. loopback, then INIT mid-byte
        bus_write(XCSR, 2'b01, 16'o000004);
        bus_read(XCSR, 16'o000204);
        bus_write(XBUF, 2'b01, 16'h003C);
        seen_low = 1'b0;
        repeat (11 * BD + 30) begin
            @(negedge clk_sys);
            if (txd !== 1'b1) seen_low = 1'b1;
        end
        chk1("maint_txd_high", seen_low, 1'b0);
        bus_read(RCSR, 16'o000200);
        bus_read(RBUF, 16'h003C);
        bus_write(XCSR, 2'b01, 16'o000000);
        bus_write(RCSR, 2'b01, 16'o000100);
        tx_mon_en = 1'b0;
        bus_write(XBUF, 2'b01, 16'h0077);
        repeat (40) @(negedge clk_sys);
        bus_reset = 1'b1;
        @(negedge clk_sys);
        bus_reset = 1'b0;
        chk1("abort_txd_next", txd, 1'b1);
        seen_low = 1'b0;
        repeat (200) begin
            @(negedge clk_sys);
            if (txd !== 1'b1) seen_low = 1'b1;
        end
        chk1("abort_txd_stays_high", seen_low, 1'b0);
        bus_read(XCSR, 16'o000200);
        bus_read(RCSR, 16'o000000);

        repeat (5) @(negedge clk_sys);
        chk16("rd_queue_empty", 16'(exp_rd.size()), 16'd0);
        chk16("tx_queue_empty", 16'(exp_tx.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
